ysyx_25020037_lsu_axi: RTL

Parametrised load/store unit between EXU and WBU; next generation of the single-word LSU. Adds byte/half/word(/dword) sizes with lane alignment and sign/zero extension, independent AW and W handshakes, misalignment trapping without bus access, and bus error reporting. Drives one AXI4-Lite-style master port with a single outstanding transaction.

---
 rtl/ysyx_25020037_lsu_axi.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_25020037_lsu_axi.sv
// ============================================================================
// Module  : ysyx_25020037_lsu_axi
// Brief   : Load/store unit with sized, lane-aligned accesses over an
//           AXI4-Lite master port; one outstanding transaction.
//           Optional macro LSU_TIMEOUT_EN adds a 16-bit slave-hang abort.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ysyx_25020037_lsu_axi #(
    parameter int  ADDR_W = 32,
    parameter int  DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // EXU request
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    // WBU result
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [1:0]        out_err_code,
    // AXI read address / data
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    // AXI write address / data / response
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    localparam int OFF_W = $clog2(STRB_W);

    localparam logic [1:0] c_ERR_NONE  = 2'd0;
    localparam logic [1:0] c_ERR_ALIGN = 2'd1;
    localparam logic [1:0] c_ERR_BUS   = 2'd2;
    localparam logic [1:0] c_ERR_TMO   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW_W = 3'd3,
        S_B    = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic [DATA_W-1:0] r_out_data;
    logic              r_err;
    logic [1:0]        r_err_code;
    logic              r_aw_done;
    logic              r_w_done;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic              w_accept;
    logic              w_req_mem;
    logic              w_misaligned;
    logic [OFF_W-1:0]  w_req_off;
    logic [7:0]        w_req_mask;
    logic [STRB_W-1:0] w_req_wstrb;
    logic [DATA_W-1:0] w_req_wdata;

    assign w_accept  = in_valid & in_ready;
    assign w_req_mem = req_load | req_store;
    assign w_req_off = req_addr[OFF_W-1:0];

    // A dword request on a 32-bit bus has no legal lane, so it traps like a misalignment
    always_comb begin
        w_misaligned = 1'b0;
        w_req_mask   = 8'h01;
        case (req_size)
            2'd0: begin
                w_misaligned = 1'b0;
                w_req_mask   = 8'h01;
            end
            2'd1: begin
                w_misaligned = req_addr[0];
                w_req_mask   = 8'h03;
            end
            2'd2: begin
                w_misaligned = |req_addr[1:0];
                w_req_mask   = 8'h0F;
            end
            default: begin
                w_misaligned = (DATA_W == 64) ? (|req_addr[2:0]) : 1'b1;
                w_req_mask   = 8'hFF;
            end
        endcase
    end

    assign w_req_wstrb = STRB_W'(w_req_mask) << w_req_off;
    assign w_req_wdata = req_wdata << {w_req_off, 3'b000};

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
    logic w_aw_fin, w_w_fin;
    logic w_busy;
    logic w_tmo_hit;

    assign w_ar_hs  = arvalid & arready;
    assign w_r_hs   = rvalid & rready;
    assign w_aw_hs  = awvalid & awready;
    assign w_w_hs   = wvalid & wready;
    assign w_b_hs   = bvalid & bready;
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done | w_w_hs;
    assign w_busy   = (r_state == S_AR) || (r_state == S_R) ||
                      (r_state == S_AW_W) || (r_state == S_B);

`ifdef LSU_TIMEOUT_EN
    logic [15:0] r_tmo;

    // Restarts on every state change so each bus phase gets its own budget
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= 16'd0;
        end else if (!w_busy || (w_state_nxt != r_state)) begin
            r_tmo <= 16'd0;
        end else begin
            r_tmo <= r_tmo + 16'd1;
        end
    end

    assign w_tmo_hit = w_busy && (r_tmo == 16'hFFFF);
`else
    assign w_tmo_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Load lane extraction and extension
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_rshift;
    logic [DATA_W-1:0] w_load_data;

    assign w_rshift = rdata >> {r_addr[OFF_W-1:0], 3'b000};

    always_comb begin
        w_load_data = w_rshift;
        case (r_size)
            2'd0: begin
                if (r_unsigned) w_load_data = DATA_W'(w_rshift[7:0]);
                else            w_load_data = DATA_W'($signed(w_rshift[7:0]));
            end
            2'd1: begin
                if (r_unsigned) w_load_data = DATA_W'(w_rshift[15:0]);
                else            w_load_data = DATA_W'($signed(w_rshift[15:0]));
            end
            2'd2: begin
                if (r_unsigned) w_load_data = DATA_W'(w_rshift[31:0]);
                else            w_load_data = DATA_W'($signed(w_rshift[31:0]));
            end
            default: w_load_data = w_rshift;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_req_mem || w_misaligned) w_state_nxt = S_DONE;
                    else if (req_load)              w_state_nxt = S_AR;
                    else                            w_state_nxt = S_AW_W;
                end
            end
            S_AR:   if (w_ar_hs)              w_state_nxt = S_R;
            S_R:    if (w_r_hs)               w_state_nxt = S_DONE;
            S_AW_W: if (w_aw_fin && w_w_fin)  w_state_nxt = S_B;
            S_B:    if (w_b_hs)               w_state_nxt = S_DONE;
            S_DONE: if (out_ready)            w_state_nxt = S_IDLE;
            default:                          w_state_nxt = S_IDLE;
        endcase
        if (w_tmo_hit) begin
            w_state_nxt = S_DONE;
        end
    end

    // ------------------------------------------------------------------
    // Request capture and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_out_data <= '0;
            r_err      <= 1'b0;
            r_err_code <= c_ERR_NONE;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_wdata    <= w_req_wdata;
            r_wstrb    <= w_req_wstrb;
            r_out_data <= w_req_mem ? '0 : DATA_W'(req_addr);
            r_err      <= w_req_mem & w_misaligned;
            r_err_code <= (w_req_mem & w_misaligned) ? c_ERR_ALIGN : c_ERR_NONE;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else if (w_tmo_hit) begin
            r_out_data <= '0;
            r_err      <= 1'b1;
            r_err_code <= c_ERR_TMO;
        end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            if (w_r_hs) begin
                if (rresp != 2'b00) begin
                    r_out_data <= '0;
                    r_err      <= 1'b1;
                    r_err_code <= c_ERR_BUS;
                end else begin
                    r_out_data <= w_load_data;
                end
            end
            if (w_b_hs && (bresp != 2'b00)) begin
                r_err      <= 1'b1;
                r_err_code <= c_ERR_BUS;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready     = (r_state == S_IDLE);
    assign out_valid    = (r_state == S_DONE);
    assign out_data     = r_out_data;
    assign out_err      = r_err;
    assign out_err_code = r_err_code;

    assign araddr  = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign awaddr  = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign arvalid = (r_state == S_AR);
    assign rready  = (r_state == S_R);
    assign awvalid = (r_state == S_AW_W) && !r_aw_done;
    assign wvalid  = (r_state == S_AW_W) && !r_w_done;
    assign bready  = (r_state == S_B);
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;

endmodule

`default_nettype wire
